pir_alarm_sequencer: RTL

- Control core of the motion-detection system; sits between the three PIR sensor inputs and the alarm output/indicator logic.
- Scans the 7-bit PIR channels round-robin, one channel per cycle, and debounces each channel against a threshold.
- Sequences the system through its states: off, arming, armed, alarm and cooldown.
- Handles the system enable (turn) and the operator acknowledge (stop_alarm).

---
 rtl/pir_alarm_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pir_alarm_sequencer.sv
// pir_alarm_sequencer: control core of the PIR motion-detection system.
// Scans three 7-bit PIR channels round-robin, debounces each one against a
// threshold and steps the system through OFF, ARMING, ARMED, ALARM and COOLDOWN.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   turn         system enable; low forces OFF on the next edge
//   stop_alarm   operator acknowledge, level-sampled, only acted on in ALARM
//   pir_sensor_1 PIR channel 0 value
//   pir_sensor_2 PIR channel 1 value
//   pir_sensor_3 PIR channel 2 value
//   alarm        registered alarm drive, high only in ALARM
//   zone         OR of the channels that triggered (bit k = channel k)
//   state        encoded FSM state: OFF=0 ARMING=1 ARMED=2 ALARM=3 COOLDOWN=4
//   scan_sel     channel sampled this cycle
//   event_count  ALARM entries since reset, saturating at 255
module pir_alarm_sequencer #(
   parameter int unsigned THRESHOLD       = 20,
   parameter int unsigned HOLD_SAMPLES    = 3,
   parameter int unsigned ARM_DELAY       = 16,
   parameter int unsigned ALARM_TIMEOUT   = 1000,
   parameter int unsigned COOLDOWN_CYCLES = 32,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       turn,
   input  logic       stop_alarm,
   input  logic [6:0] pir_sensor_1,
   input  logic [6:0] pir_sensor_2,
   input  logic [6:0] pir_sensor_3,
   output logic       alarm,
   output logic [2:0] zone,
   output logic [2:0] state,
   output logic [1:0] scan_sel,
   output logic [7:0] event_count
);

   localparam logic [2:0] StOff      = 3'd0;
   localparam logic [2:0] StArming   = 3'd1;
   localparam logic [2:0] StArmed    = 3'd2;
   localparam logic [2:0] StAlarm    = 3'd3;
   localparam logic [2:0] StCooldown = 3'd4;

   localparam logic [6:0]       Thr        = 7'(THRESHOLD);
   localparam logic [3:0]       Hold       = 4'(HOLD_SAMPLES);
   localparam logic [CNT_W-1:0] ArmLast    = CNT_W'(ARM_DELAY - 1);
   localparam logic [CNT_W-1:0] AlarmLast  = CNT_W'(ALARM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CoolLast   = CNT_W'(COOLDOWN_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             alarm_q, alarm_d;
   logic [2:0]       zone_q, zone_d;
   logic [1:0]       sel_q, sel_d, sel_nxt;
   logic [7:0]       evt_q, evt_d;
   logic [2:0][3:0]  hit_q, hit_d, hit_upd;
   logic [2:0]       trig;
   logic [6:0]       sample;
   logic             qualify;

   // Scanner: only the selected channel's hit counter moves each cycle.
   always_comb begin
      case (sel_q)
         2'd1:    sample = pir_sensor_2;
         2'd2:    sample = pir_sensor_3;
         default: sample = pir_sensor_1;
      endcase
      qualify = (sample >= Thr);
      sel_nxt = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      hit_upd = hit_q;
      trig    = '0;
      for (int k = 0; k < 3; k++) begin
         if (sel_q == 2'(k)) begin
            if (!qualify) begin
               hit_upd[k] = '0;
            end else if (hit_q[k] < Hold) begin
               hit_upd[k] = hit_q[k] + 4'd1;
               // Trigger only on the transition into HOLD, not while saturated.
               trig[k]    = ((hit_q[k] + 4'd1) == Hold);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      alarm_d = alarm_q;
      zone_d  = zone_q;
      sel_d   = sel_q;
      hit_d   = hit_q;
      evt_d   = evt_q;
      if (!turn) begin
         state_d = StOff;
         timer_d = '0;
         alarm_d = 1'b0;
         zone_d  = '0;
         sel_d   = '0;
         hit_d   = '0;
      end else begin
         case (state_q)
            StOff: begin
               state_d = StArming;
               timer_d = '0;
            end
            StArming: begin
               if (timer_q == ArmLast) begin
                  state_d = StArmed;
                  timer_d = '0;
                  sel_d   = '0;
                  hit_d   = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            StArmed: begin
               sel_d = sel_nxt;
               hit_d = hit_upd;
               if (|trig) begin
                  state_d = StAlarm;
                  alarm_d = 1'b1;
                  zone_d  = zone_q | trig;
                  timer_d = '0;
                  if (evt_q != 8'hFF) evt_d = evt_q + 8'd1;
               end
            end
            StAlarm: begin
               // Acknowledge and timeout share one exit path.
               if (stop_alarm || (timer_q == AlarmLast)) begin
                  state_d = StCooldown;
                  alarm_d = 1'b0;
                  hit_d   = '0;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
                  sel_d   = sel_nxt;
                  hit_d   = hit_upd;
                  zone_d  = zone_q | trig;
               end
            end
            StCooldown: begin
               if (timer_q == CoolLast) begin
                  state_d = StArmed;
                  zone_d  = '0;
                  sel_d   = '0;
                  hit_d   = '0;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               state_d = StOff;
               timer_d = '0;
               alarm_d = 1'b0;
               zone_d  = '0;
               sel_d   = '0;
               hit_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StOff;
         timer_q <= '0;
         alarm_q <= 1'b0;
         zone_q  <= '0;
         sel_q   <= '0;
         hit_q   <= '0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         alarm_q <= alarm_d;
         zone_q  <= zone_d;
         sel_q   <= sel_d;
         hit_q   <= hit_d;
         evt_q   <= evt_d;
      end
   end

   assign alarm       = alarm_q;
   assign zone        = zone_q;
   assign state       = state_q;
   assign scan_sel    = sel_q;
   assign event_count = evt_q;

endmodule
